// File: rtl/mdu_pkg.sv
// Shared RV32M definitions for the iterative multiply/divide unit:
// Funct3 op encodings, FSM state type and per-op signedness helpers.
package mdu_pkg;

  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  localparam logic [6:0] MDU_FUNCT7 = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } mdu_state_t;

  function automatic logic is_div(input logic [2:0] funct3);
    return funct3[2];
  endfunction

  function automatic logic a_signed(input logic [2:0] funct3);
    return (funct3 == MDU_MULH) || (funct3 == MDU_MULHSU) ||
           (funct3 == MDU_DIV)  || (funct3 == MDU_REM);
  endfunction

  function automatic logic b_signed(input logic [2:0] funct3);
    return (funct3 == MDU_MULH) || (funct3 == MDU_DIV) || (funct3 == MDU_REM);
  endfunction

endpackage

// File: rtl/mdu_abs_neg.sv
// Conditional two's-complement negate; yields a magnitude from a signed value
// or re-applies a sign to an unsigned result.
module mdu_abs_neg #(
  parameter int W = 32
) (
  input  logic [W-1:0] value,
  input  logic         negate,
  output logic [W-1:0] result
);

  assign result = negate ? (~value + W'(1)) : value;

endmodule

// File: rtl/mdu_sequencer.sv
// RV32M multi-cycle multiply/divide unit: radix-2 shift-add multiplier and
// restoring divider on operand magnitudes, followed by a sign fix-up.
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       Funct3,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] Result
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  mdu_state_t           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           op_q, op_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     oper_q, oper_d;
  logic [WIDTH-1:0]     res_q, res_d;

  logic                 sign_a, sign_b;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic                 div_by_zero, div_ovf;
  logic [WIDTH-1:0]     special_res;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_rem;
  logic [WIDTH:0]       div_diff;
  logic [2*WIDTH-1:0]   fix_in, fix_out;
  logic [WIDTH-1:0]     fix_word;

  assign sign_a = a_signed(Funct3) & SrcA[WIDTH-1];
  assign sign_b = b_signed(Funct3) & SrcB[WIDTH-1];

  mdu_abs_neg #(.W(WIDTH)) u_abs_a (
    .value  (SrcA),
    .negate (sign_a),
    .result (mag_a)
  );

  mdu_abs_neg #(.W(WIDTH)) u_abs_b (
    .value  (SrcB),
    .negate (sign_b),
    .result (mag_b)
  );

  assign div_by_zero = is_div(Funct3) && (SrcB == '0);
  assign div_ovf     = ((Funct3 == MDU_DIV) || (Funct3 == MDU_REM)) &&
                       (SrcA == MIN_NEG) && (SrcB == '1);
  // Funct3[1] separates the remainder ops from the quotient ops.
  assign special_res = Funct3[1] ? (div_by_zero ? SrcA : '0)
                                 : (div_by_zero ? '1 : MIN_NEG);

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? oper_q : '0)};
  assign div_rem  = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff = div_rem - {1'b0, oper_q};

  assign fix_in = is_div(op_q)
                  ? {{WIDTH{1'b0}}, (op_q[1] ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0])}
                  : acc_q;

  mdu_abs_neg #(.W(2*WIDTH)) u_fix (
    .value  (fix_in),
    .negate (neg_q),
    .result (fix_out)
  );

  assign fix_word = ((op_q == MDU_MUL) || is_div(op_q)) ? fix_out[WIDTH-1:0]
                                                         : fix_out[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    oper_d  = oper_q;
    res_d   = res_q;

    unique case (state_q)
      IDLE: begin
        if (start && !flush) begin
          op_d  = Funct3;
          cnt_d = CW'(WIDTH-1);
          // Remainder follows the dividend; everything else follows sign(A)^sign(B).
          neg_d = (Funct3 == MDU_REM) ? sign_a : (sign_a ^ sign_b);
          if (div_by_zero || div_ovf) begin
            res_d   = special_res;
            state_d = DONE;
          end else begin
            if (is_div(Funct3)) begin
              acc_d  = {{WIDTH{1'b0}}, mag_a};
              oper_d = mag_b;
            end else begin
              acc_d  = {{WIDTH{1'b0}}, mag_b};
              oper_d = mag_a;
            end
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (is_div(op_q)) begin
          acc_d = div_diff[WIDTH]
                  ? {div_rem[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b0}
                  : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = FIX;
        end
      end
      FIX: begin
        res_d   = fix_word;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (flush) begin
      state_d = IDLE;
      res_d   = res_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      oper_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      oper_q  <= oper_d;
      res_q   <= res_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign stall  = start && !done;
  assign Result = res_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: an arithmetic reference model tracks
// expected busy/done/stall/Result each cycle, plus directed literal checks.
module tb_mdu_sequencer;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [2:0]  Funct3;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        flush;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] Result;

  int n_vectors = 0;
  int n_miscompares = 0;

  bit          m_active = 1'b0;
  int          m_k = 0;
  int          m_lat = 0;
  logic [31:0] m_exp = '0;
  logic [31:0] m_last = '0;

  mdu_sequencer #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .Funct3  (Funct3),
    .SrcA    (SrcA),
    .SrcB    (SrcB),
    .flush   (flush),
    .busy    (busy),
    .stall   (stall),
    .done    (done),
    .Result  (Result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input longint got, input longint exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Architectural result of an RV32M op computed with plain wide arithmetic.
  task automatic ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] r, output int lat);
    longint      sa, sb, ub;
    logic [63:0] p;
    int          ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    ia = a;
    ib = b;
    lat = 34;
    r = '0;
    case (f)
      3'b000: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
      3'b001: begin p = sa * sb; r = p[63:32]; end
      3'b010: begin p = sa * ub; r = p[63:32]; end
      3'b011: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
      3'b100: begin
        if (b == 0) begin r = 32'hFFFF_FFFF; lat = 1; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin r = 32'h8000_0000; lat = 1; end
        else r = ia / ib;
      end
      3'b101: begin
        if (b == 0) begin r = 32'hFFFF_FFFF; lat = 1; end
        else r = a / b;
      end
      3'b110: begin
        if (b == 0) begin r = a; lat = 1; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin r = 0; lat = 1; end
        else r = ia % ib;
      end
      default: begin
        if (b == 0) begin r = a; lat = 1; end
        else r = a % b;
      end
    endcase
  endtask

  always @(posedge clk) begin
    if (reset_n) begin
      if (m_active) begin
        if (m_k == m_lat) m_last = m_exp;
        if (flush || m_k == m_lat) m_active = 1'b0;
        else m_k++;
      end else if (start && !flush) begin
        ref_result(Funct3, SrcA, SrcB, m_exp, m_lat);
        m_active = 1'b1;
        m_k = 1;
      end
    end
  end

  always @(negedge reset_n) begin
    m_active = 1'b0;
    m_k = 0;
    m_last = '0;
  end

  always @(negedge clk) begin
    if (reset_n) begin
      logic        exp_done;
      logic [31:0] exp_res;
      exp_done = m_active && (m_k == m_lat);
      exp_res  = exp_done ? m_exp : m_last;
      checkOutput("busy", longint'(busy), longint'(m_active));
      checkOutput("done", longint'(done), longint'(exp_done));
      checkOutput("stall", longint'(stall), longint'(start && !exp_done));
      checkOutput("Result", longint'(Result), longint'(exp_res));
    end
  end

  // Drives one op, waits (bounded) for done and reports result, latency and busy cycles.
  task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] res, output int lat, output int busy_cycles,
                               output logic stall_at_done);
    bit seen;
    @(posedge clk); #2;
    start = 1'b1; Funct3 = f; SrcA = a; SrcB = b;
    @(posedge clk);
    lat = 0; busy_cycles = 0; res = '0; stall_at_done = 1'bx; seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      lat++;
      if (busy) busy_cycles++;
      if (done) begin
        res = Result;
        stall_at_done = stall;
        seen = 1;
        break;
      end
    end
    if (!seen) lat = -1;
  endtask

  task automatic stopStart();
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic directed(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    logic [31:0] res;
    int          lat, bc;
    logic        st;
    applyStimulus(f, a, b, res, lat, bc, st);
    checkOutput({name, "_result"}, longint'(res), longint'(exp_res));
    checkOutput({name, "_latency"}, longint'(lat), longint'(exp_lat));
    stopStart();
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] res;
    int          lat, bc, done_count;
    logic        st;

    reset_n = 1'b0; start = 1'b0; flush = 1'b0;
    Funct3 = '0; SrcA = '0; SrcB = '0;
    #3;
    checkOutput("reset_busy", longint'(busy), 0);
    checkOutput("reset_done", longint'(done), 0);
    checkOutput("reset_Result", longint'(Result), 0);
    #9 reset_n = 1'b1;

    applyStimulus(3'b000, 32'd7, 32'hFFFF_FFFD, res, lat, bc, st);
    checkOutput("mul_result", longint'(res), 64'hFFFF_FFEB);
    checkOutput("mul_latency", longint'(lat), 34);
    checkOutput("mul_busy_cycles", longint'(bc), 34);
    checkOutput("mul_stall_at_done", longint'(st), 0);
    stopStart();

    directed("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
    directed("mulhu",  3'b011, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
    directed("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 34);
    directed("div",    3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34);
    directed("rem",    3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34);
    directed("divu",   3'b101, 32'd100,       32'd7,         32'd14,        34);
    directed("remu",   3'b111, 32'd100,       32'd7,         32'd2,         34);
    directed("divu_by0", 3'b101, 32'd100,       32'd0,         32'hFFFF_FFFF, 1);
    directed("rem_by0",  3'b110, 32'd100,       32'd0,         32'd100,       1);
    directed("div_ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    directed("rem_ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);
    directed("divu_pre", 3'b101, 32'd100,       32'd7,         32'd14,        34);

    // Flush in the middle of CALC: back to IDLE, no done, Result keeps 14.
    @(posedge clk); #2;
    start = 1'b1; Funct3 = 3'b000; SrcA = 32'd9; SrcB = 32'd9;
    @(posedge clk);
    repeat (10) @(negedge clk);
    @(posedge clk); #2;
    flush = 1'b1; start = 1'b0;
    @(posedge clk); #2;
    flush = 1'b0;
    @(negedge clk);
    checkOutput("flush_busy", longint'(busy), 0);
    checkOutput("flush_Result", longint'(Result), 14);
    done_count = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) done_count++;
    end
    checkOutput("flush_no_done", longint'(done_count), 0);

    // Asynchronous reset in the middle of CALC.
    @(posedge clk); #2;
    start = 1'b1; Funct3 = 3'b000; SrcA = 32'd11; SrcB = 32'd13;
    @(posedge clk);
    repeat (5) @(negedge clk);
    #3 reset_n = 1'b0;
    #1;
    checkOutput("areset_busy", longint'(busy), 0);
    checkOutput("areset_Result", longint'(Result), 0);
    checkOutput("areset_done", longint'(done), 0);
    start = 1'b0;
    @(posedge clk); #3 reset_n = 1'b1;
    directed("mul_after_reset", 3'b000, 32'd3, 32'd5, 32'd15, 34);

    // Back-to-back: start stays high across DONE with new operands.
    applyStimulus(3'b000, 32'd2, 32'd3, res, lat, bc, st);
    checkOutput("b2b_first_result", longint'(res), 6);
    checkOutput("b2b_first_latency", longint'(lat), 34);
    applyStimulus(3'b101, 32'd9, 32'd3, res, lat, bc, st);
    checkOutput("b2b_second_result", longint'(res), 3);
    checkOutput("b2b_second_latency", longint'(lat), 34);
    stopStart();

    for (int c = 0; c < 6000; c++) begin
      @(posedge clk); #2;
      start  = ($urandom_range(0, 9) < 7);
      flush  = ($urandom_range(0, 149) == 0);
      Funct3 = 3'($urandom_range(0, 7));
      SrcA   = rnd_operand();
      SrcB   = rnd_operand();
    end
    @(posedge clk); #2;
    start = 1'b0; flush = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Iterative multi-cycle multiply/divide unit and its controller for the RV32M extension. It sits in the execute stage beside the single-cycle ALU.
- It is selected when the main decoder flags an M-type instruction (opcode 0110011, Funct7 0000001). It receives Funct3 and both operands.
- It stalls the pipeline until the result is ready, then writes back through the ALU result mux.
- It runs a radix-2 shift-add multiplier and a restoring divider on operand magnitudes, then applies a sign fix-up.

Parameters:
WIDTH, 32, operand/result width in bits; iteration count equals WIDTH

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  M-type op present in EX; held high by pipeline until done
Funct3  input  3  RV32M op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
SrcA  input  WIDTH  rs1 operand
SrcB  input  WIDTH  rs2 operand
flush  input  1  synchronous abort (branch/jump flush of EX)
busy  output  1  high in every state except IDLE
stall  output  1  start && !done (combinational); freezes IF/ID/EX
done  output  1  one-cycle pulse; result valid
Result  output  WIDTH  operation result, held until next done

Behaviour:
- Reset (async, reset_n=0): state=IDLE; busy=0, done=0, Result=0; all internal registers (accumulator, operand, counter, sign flags, op) cleared.
- States: IDLE, CALC, FIX, DONE.
- IDLE: if start and !flush, latch Funct3, signs and magnitudes of SrcA/SrcB.
  - Magnitudes come from per-op signedness: MULH/DIV/REM both signed; MULHSU only A signed; others unsigned.
  - counter = WIDTH-1.
  - Divide by zero (B=0, ops 1xx), or signed overflow (DIV/REM with A=0x80000000, B=0xFFFFFFFF): load the special result and go to DONE.
  - Otherwise go to CALC.
- CALC: one iteration per cycle; counter decrements; at counter==0, go to FIX.
  - Multiply: 2*WIDTH-bit product accumulated by shift-add.
  - Divide: 1 quotient bit and partial remainder update per cycle.
- FIX: select the result and apply sign, then go to DONE.
  - MUL: low word. MULH/MULHSU/MULHU: high word. Negate the 2*WIDTH product if the operand signs differ.
  - DIV: quotient, negated if signs differ.
  - REM: remainder, takes the dividend's sign.
  - Unsigned ops: no fix-up.
- DONE: done=1, Result driven from the result register; next state IDLE unconditionally. start is ignored in DONE.
- Latency:
  - Normal op: done asserts WIDTH+2 cycles after the start-accept edge (34 for WIDTH=32).
  - Special case: done asserts on the cycle after accept.
- Back-to-back ops: start still high in IDLE after DONE is a new instruction and is accepted.
- Special results:
  - DIV/DIVU by 0: quotient all-ones.
  - REM/REMU by 0: remainder = SrcA.
  - Overflow: DIV gives 0x80000000, REM gives 0.
- Operand changes on SrcA/SrcB/Funct3 after accept have no effect; the latched copies are used.
- flush: in any state, the next edge goes to IDLE, no done pulse, Result unchanged. flush with start in IDLE does not accept.
- Reset mid-operation: immediate IDLE, outputs to reset values; no done.
- Result holds its last value outside DONE.
- stall drops in the same cycle done rises, so the pipeline advances on that edge.

Decomposition:
- Shared package mdu_pkg:
  - Funct3 encodings (MDU_MUL … MDU_REMU) and the M-extension Funct7 constant 7'b0000001.
  - mdu_state_t enum {IDLE, CALC, FIX, DONE}.
  - Helper functions is_div(funct3) and a_signed/b_signed(funct3).
- One sub-module: mdu_abs_neg, a combinational conditional two's-complement negate of WIDTH or 2*WIDTH bits. It is used for operand magnitudes and for the FIX sign correction.
- The FSM, counter and iteration datapath live in mdu_sequencer.

Test Plan:
- MUL SrcA=7, SrcB=0xFFFFFFFD (-3), start held → done exactly 34 cycles after accept, Result=0xFFFFFFEB; busy high for those 34 cycles, stall low on the done cycle.
- MULH SrcA=SrcB=0x80000000 → Result=0x40000000; MULHU same operands → 0x40000000; MULHSU SrcA=0xFFFFFFFF, SrcB=2 → 0xFFFFFFFF.
- DIV SrcA=0xFFFFFFF9 (-7), SrcB=2 → 0xFFFFFFFD; REM same → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- Special cases, each with done 1 cycle after accept:
  - DIVU 100/0 → 0xFFFFFFFF.
  - REM 100/0 → 100.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM same operands → 0.
- Abort/reset: flush at CALC cycle 10 → IDLE next edge, no done, Result keeps its prior value. Separately, reset_n low mid-CALC (asynchronously, off clock edge) → busy=0 and Result=0 immediately. A following MUL 3*5 → 15 with normal latency.
- Back-to-back: MUL 2*3, then start stays high with new operands DIVU 9/3 → two done pulses, Results 6 then 3; the second accept occurs on the edge after DONE.
